// File: rtl/work_pool_pkg.sv
// work_pool shared constants: default geometry, slot count, word indexing.
// Optional checksum feature is enabled by defining WORK_POOL_CHK_EN.
package work_pool_pkg;

  localparam int PKG_LEN_DEF = 10;
  localparam int WORD_W_DEF  = 32;
  localparam int POOL_SLOTS  = 2;

  function automatic int word_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/work_pool_asm.sv
// work_pool packet assembler: word counter, assembly words, optional XOR check.
// Checksum logic is present only when WORK_POOL_CHK_EN is defined.
module work_pool_asm
  import work_pool_pkg::*;
#(
  parameter int PKG_LEN = PKG_LEN_DEF,
  parameter int WORD_W  = WORD_W_DEF,
  parameter int CNT_W   = 4
) (
  input  logic                      CLK_I,
  input  logic                      RST_N_I,
  input  logic                      push,
  input  logic [WORD_W-1:0]         din,
  input  logic                      flush,
  output logic [CNT_W-1:0]          asm_cnt,
  output logic                      pkt_done,
  output logic [PKG_LEN*WORD_W-1:0] pkt_dat,
  output logic                      chk_ok
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PKG_LEN - 1);

  logic [WORD_W-1:0] words_q [PKG_LEN-1];
  logic              acc;

  assign acc      = push & ~flush;
  assign pkt_done = acc & (asm_cnt == LAST);

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      asm_cnt <= '0;
    end else if (flush || pkt_done) begin
      asm_cnt <= '0;
    end else if (push) begin
      asm_cnt <= asm_cnt + 1'b1;
    end
  end

  // Payload storage carries no reset; validity is tracked by asm_cnt.
  always_ff @(posedge CLK_I) begin
    for (int i = 0; i < PKG_LEN - 1; i++) begin
      if (acc && asm_cnt == CNT_W'(i)) words_q[i] <= din;
    end
  end

  // Last word bypasses storage so the packet is whole on the commit push.
  always_comb begin
    pkt_dat = '0;
    for (int i = 0; i < PKG_LEN - 1; i++) begin
      pkt_dat[word_lo(i, WORD_W) +: WORD_W] = words_q[i];
    end
    pkt_dat[word_lo(PKG_LEN - 1, WORD_W) +: WORD_W] = din;
  end

`ifdef WORK_POOL_CHK_EN
  logic [WORD_W-1:0] xor_q;

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      xor_q <= '0;
    end else if (flush || pkt_done) begin
      xor_q <= '0;
    end else if (acc) begin
      xor_q <= xor_q ^ din;
    end
  end

  assign chk_ok = (din == xor_q);
`else
  assign chk_ok = 1'b1;
`endif

endmodule

// File: rtl/work_pool.sv
// work_pool: assembles pushed words into packets held in a 2-slot ping-pong.
// Define WORK_POOL_CHK_EN to drop packets whose last word fails the XOR check.
module work_pool
  import work_pool_pkg::*;
#(
  parameter int PKG_LEN = PKG_LEN_DEF,
  parameter int WORD_W  = WORD_W_DEF,
  parameter int CNT_W   = 4
) (
  input  logic                      CLK_I,
  input  logic                      RST_N_I,
  input  logic                      pool_push,
  input  logic [WORD_W-1:0]         pool_din,
  input  logic                      pool_flush,
  input  logic                      err_clr,
  output logic                      work_vld,
  input  logic                      work_rdy,
  output logic [PKG_LEN*WORD_W-1:0] work_dat,
  output logic [1:0]                pool_cnt,
  output logic                      pool_full,
  output logic [CNT_W-1:0]          asm_cnt,
  output logic                      ovf_err,
  output logic                      chk_err
);

  localparam int PKT_W = PKG_LEN * WORD_W;

  logic [PKT_W-1:0]      slot_q [POOL_SLOTS];
  logic [POOL_SLOTS-1:0] full_q;
  logic [POOL_SLOTS-1:0] full_d;
  logic                  wr_ptr;
  logic                  rd_ptr;

  logic             pkt_done;
  logic [PKT_W-1:0] pkt_dat;
  logic             chk_ok;
  logic             xfer;
  logic             slot_free;
  logic             commit;
  logic             ovf_set;

  work_pool_asm #(
    .PKG_LEN (PKG_LEN),
    .WORD_W  (WORD_W),
    .CNT_W   (CNT_W)
  ) u_asm (
    .CLK_I    (CLK_I),
    .RST_N_I  (RST_N_I),
    .push     (pool_push),
    .din      (pool_din),
    .flush    (pool_flush),
    .asm_cnt  (asm_cnt),
    .pkt_done (pkt_done),
    .pkt_dat  (pkt_dat),
    .chk_ok   (chk_ok)
  );

  assign work_vld  = |full_q;
  assign pool_cnt  = {full_q[0] & full_q[1], full_q[0] ^ full_q[1]};
  assign pool_full = &full_q;
  assign work_dat  = work_vld ? slot_q[rd_ptr] : '0;

  // With both slots full the pointers coincide, so a same-cycle read frees wr slot.
  assign xfer      = work_vld & work_rdy;
  assign slot_free = ~full_q[wr_ptr] | (xfer & (rd_ptr == wr_ptr));
  assign commit    = pkt_done & chk_ok & slot_free;
  assign ovf_set   = pkt_done & chk_ok & ~slot_free;

  always_comb begin
    full_d = full_q;
    if (xfer)   full_d[rd_ptr] = 1'b0;
    if (commit) full_d[wr_ptr] = 1'b1;
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      full_q  <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      full_q  <= full_d;
      wr_ptr  <= wr_ptr ^ commit;
      rd_ptr  <= rd_ptr ^ xfer;
      ovf_err <= ovf_set | (ovf_err & ~err_clr);
    end
  end

  always_ff @(posedge CLK_I) begin
    if (commit) slot_q[wr_ptr] <= pkt_dat;
  end

`ifdef WORK_POOL_CHK_EN
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      chk_err <= 1'b0;
    end else begin
      chk_err <= (pkt_done & ~chk_ok) | (chk_err & ~err_clr);
    end
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_work_pool.sv
// tb_work_pool: directed and random stimulus against a queue-based model.
// Build with WORK_POOL_CHK_EN defined to exercise the checksum path.
module tb_work_pool;

  localparam int PKG_LEN = 10;
  localparam int WORD_W  = 32;
  localparam int CNT_W   = 4;
  localparam int PW      = PKG_LEN * WORD_W;

  logic              CLK_I = 1'b0;
  logic              RST_N_I = 1'b0;
  logic              pool_push = 1'b0;
  logic [WORD_W-1:0] pool_din = '0;
  logic              pool_flush = 1'b0;
  logic              err_clr = 1'b0;
  logic              work_vld;
  logic              work_rdy = 1'b0;
  logic [PW-1:0]     work_dat;
  logic [1:0]        pool_cnt;
  logic              pool_full;
  logic [CNT_W-1:0]  asm_cnt;
  logic              ovf_err;
  logic              chk_err;

  work_pool #(
    .PKG_LEN (PKG_LEN),
    .WORD_W  (WORD_W),
    .CNT_W   (CNT_W)
  ) dut (
    .CLK_I      (CLK_I),
    .RST_N_I    (RST_N_I),
    .pool_push  (pool_push),
    .pool_din   (pool_din),
    .pool_flush (pool_flush),
    .err_clr    (err_clr),
    .work_vld   (work_vld),
    .work_rdy   (work_rdy),
    .work_dat   (work_dat),
    .pool_cnt   (pool_cnt),
    .pool_full  (pool_full),
    .asm_cnt    (asm_cnt),
    .ovf_err    (ovf_err),
    .chk_err    (chk_err)
  );

  always #5 CLK_I = ~CLK_I;

  int tests = 0;
  int fails = 0;

  logic [WORD_W-1:0] part [$];
  logic [PW-1:0]     pkts [$];
  bit                m_ovf = 1'b0;
  bit                m_chk = 1'b0;

  task automatic check(input string tag, input logic [PW-1:0] obs,
                       input logic [PW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("work_vld", PW'(work_vld), PW'(pkts.size() != 0));
    check("pool_cnt", PW'(pool_cnt), PW'(pkts.size()));
    check("pool_full", PW'(pool_full), PW'(pkts.size() == 2));
    check("asm_cnt", PW'(asm_cnt), PW'(part.size()));
    check("ovf_err", PW'(ovf_err), PW'(m_ovf));
    check("chk_err", PW'(chk_err), PW'(m_chk));
    check("work_dat", work_dat, (pkts.size() != 0) ? pkts[0] : '0);
  endtask

  function automatic logic [WORD_W-1:0] part_xor();
    logic [WORD_W-1:0] x = '0;
    foreach (part[i]) x ^= part[i];
    return x;
  endfunction

  task automatic model_reset();
    part.delete();
    pkts.delete();
    m_ovf = 1'b0;
    m_chk = 1'b0;
  endtask

  // One clock: drive, update the model from the rules, then compare.
  task automatic step(input bit push, input logic [WORD_W-1:0] din,
                      input bit flush, input bit rdy, input bit clr);
    logic [PW-1:0] pk;
    bit ok;
    pool_push  = push;
    pool_din   = din;
    pool_flush = flush;
    work_rdy   = rdy;
    err_clr    = clr;
    @(posedge CLK_I);
    if (rdy && pkts.size() != 0) void'(pkts.pop_front());
    if (clr) begin
      m_ovf = 1'b0;
      m_chk = 1'b0;
    end
    if (flush) begin
      part.delete();
    end else if (push) begin
      if (part.size() == PKG_LEN - 1) begin
        ok = 1'b1;
`ifdef WORK_POOL_CHK_EN
        ok = (part_xor() == din);
`endif
        pk = '0;
        foreach (part[i]) pk[i*WORD_W +: WORD_W] = part[i];
        pk[(PKG_LEN-1)*WORD_W +: WORD_W] = din;
        if (!ok) m_chk = 1'b1;
        else if (pkts.size() < 2) pkts.push_back(pk);
        else m_ovf = 1'b1;
        part.delete();
      end else begin
        part.push_back(din);
      end
    end
    #1;
    pool_push  = 1'b0;
    pool_flush = 1'b0;
    work_rdy   = 1'b0;
    err_clr    = 1'b0;
    check_all();
  endtask

  task automatic push_words(input logic [WORD_W-1:0] base, input int n);
    for (int i = 0; i < n; i++) step(1'b1, base + WORD_W'(i), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    @(negedge CLK_I);
    RST_N_I = 1'b1;

    // Basic packet 1..10
    push_words(32'h1, PKG_LEN);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Fill and overflow, then deliver both in order
    push_words(32'h100, PKG_LEN);
    push_words(32'h200, PKG_LEN);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Commit with pool full and simultaneous consume
    push_words(32'h300, PKG_LEN);
    push_words(32'h400, PKG_LEN);
    push_words(32'h500, PKG_LEN - 1);
    step(1'b1, 32'h509, 1'b0, 1'b1, 1'b0);
    drain();

    // Flush, then flush coincident with a push
    push_words(32'h600, 4);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    push_words(32'hB0, PKG_LEN);
    push_words(32'h700, 3);
    step(1'b1, 32'hDEAD, 1'b1, 1'b0, 1'b0);
    push_words(32'h700, PKG_LEN - 1);
    step(1'b1, 32'h709, 1'b1, 1'b0, 1'b0);
    drain();

    // Async reset mid-packet with both slots full
    push_words(32'h800, PKG_LEN);
    push_words(32'h900, PKG_LEN);
    push_words(32'hA00, 5);
    #2 RST_N_I = 1'b0;
    #1 model_reset();
    check_all();
    #1 RST_N_I = 1'b1;
    push_words(32'hC00, PKG_LEN);
    drain();

`ifdef WORK_POOL_CHK_EN
    push_words(32'h1, PKG_LEN - 1);
    step(1'b1, 32'h1, 1'b0, 1'b0, 1'b0);
    push_words(32'h1, PKG_LEN - 1);
    step(1'b1, 32'h2, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    drain();
`endif

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      logic [WORD_W-1:0] d;
      d = $urandom;
      if (part.size() == PKG_LEN - 1 && $urandom_range(0, 1) == 1) d = part_xor();
      step($urandom_range(0, 1) == 1, d, $urandom_range(0, 39) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
